// File: rtl/occamy_ecc_event_collector.sv
// Collects per-bank ECC read-error strobes into registered interrupt events,
// saturating per-class error counters and a first-error log for software.
module occamy_ecc_event_collector #(
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned BankIdxW  = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumBanks-1:0][1:0]            bank_err_i,
  input  logic [NumBanks-1:0][AddrWidth-1:0]  bank_addr_i,
  input  logic                                clear_i,
  output logic [1:0]                          event_ecc_rerror_o,
  output logic [CntWidth-1:0]                 cnt_corr_o,
  output logic [CntWidth-1:0]                 cnt_uncorr_o,
  output logic [1:0]                          cnt_sat_o,
  output logic                                log_valid_o,
  output logic                                log_uncorr_o,
  output logic [BankIdxW-1:0]                 log_bank_o,
  output logic [AddrWidth-1:0]                log_addr_o
);

  localparam int unsigned PcW  = $clog2(NumBanks + 1);
  localparam int unsigned SumW = CntWidth + PcW;

  typedef enum logic [1:0] {LogEmpty, LogCorr, LogUncorr} log_state_e;

  function automatic logic [PcW-1:0] popcount(input logic [NumBanks-1:0] v);
    logic [PcW-1:0] n;
    n = '0;
    for (int i = 0; i < NumBanks; i++) n = n + PcW'(v[i]);
    return n;
  endfunction

  // Returns {saturated, value}; reaching the maximum already counts as saturated.
  function automatic logic [CntWidth:0] sat_add(input logic [CntWidth-1:0] cur,
                                                input logic [PcW-1:0]      n);
    logic [SumW-1:0] sum;
    logic [SumW-1:0] max;
    sum = SumW'(cur) + SumW'(n);
    max = SumW'({CntWidth{1'b1}});
    if (sum >= max) return {1'b1, {CntWidth{1'b1}}};
    return {1'b0, sum[CntWidth-1:0]};
  endfunction

  function automatic logic [BankIdxW-1:0] lowest(input logic [NumBanks-1:0] v);
    logic [BankIdxW-1:0] idx;
    idx = '0;
    for (int i = NumBanks - 1; i >= 0; i--) if (v[i]) idx = BankIdxW'(i);
    return idx;
  endfunction

  // Stage p0: effective strobes (uncorrectable dominates) and next-state logic
  logic [NumBanks-1:0]  uc_p0, c_p0;
  logic [CntWidth:0]    corr_upd_p0, uncorr_upd_p0;
  logic [1:0]           sat_d_p0;
  log_state_e           state_q, state_base, state_d;
  logic [BankIdxW-1:0]  log_bank_d;
  logic [AddrWidth-1:0] log_addr_d;

  logic [1:0]           ev_p1;
  logic [CntWidth-1:0]  cnt_corr_p1, cnt_uncorr_p1;
  logic [1:0]           sat_p1;
  logic [BankIdxW-1:0]  log_bank_p1;
  logic [AddrWidth-1:0] log_addr_p1;

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      uc_p0[b] = bank_err_i[b][1];
      c_p0[b]  = bank_err_i[b][0] & ~bank_err_i[b][1];
    end
  end

  always_comb begin
    corr_upd_p0   = sat_add(clear_i ? '0 : cnt_corr_p1, popcount(c_p0));
    uncorr_upd_p0 = sat_add(clear_i ? '0 : cnt_uncorr_p1, popcount(uc_p0));
    sat_d_p0[0]   = (~clear_i & sat_p1[0]) | corr_upd_p0[CntWidth];
    sat_d_p0[1]   = (~clear_i & sat_p1[1]) | uncorr_upd_p0[CntWidth];
  end

  // Clear acts as an empty log for this cycle's captures, so nothing is lost.
  always_comb begin
    state_base = clear_i ? LogEmpty : state_q;
    state_d    = state_base;
    log_bank_d = clear_i ? '0 : log_bank_p1;
    log_addr_d = clear_i ? '0 : log_addr_p1;
    case (state_base)
      LogEmpty, LogCorr: begin
        if (|uc_p0) begin
          state_d    = LogUncorr;
          log_bank_d = lowest(uc_p0);
          log_addr_d = bank_addr_i[lowest(uc_p0)];
        end else if (state_base == LogEmpty && |c_p0) begin
          state_d    = LogCorr;
          log_bank_d = lowest(c_p0);
          log_addr_d = bank_addr_i[lowest(c_p0)];
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_p1         <= '0;
      cnt_corr_p1   <= '0;
      cnt_uncorr_p1 <= '0;
      sat_p1        <= '0;
      state_q       <= LogEmpty;
      log_bank_p1   <= '0;
      log_addr_p1   <= '0;
    end else begin
      ev_p1         <= {|uc_p0, |c_p0};
      cnt_corr_p1   <= corr_upd_p0[CntWidth-1:0];
      cnt_uncorr_p1 <= uncorr_upd_p0[CntWidth-1:0];
      sat_p1        <= sat_d_p0;
      state_q       <= state_d;
      log_bank_p1   <= log_bank_d;
      log_addr_p1   <= log_addr_d;
    end
  end

  assign event_ecc_rerror_o = ev_p1;
  assign cnt_corr_o         = cnt_corr_p1;
  assign cnt_uncorr_o       = cnt_uncorr_p1;
  assign cnt_sat_o          = sat_p1;
  assign log_valid_o        = (state_q != LogEmpty);
  assign log_uncorr_o       = (state_q == LogUncorr);
  assign log_bank_o         = log_bank_p1;
  assign log_addr_o         = log_addr_p1;

endmodule

// File: tb/tb_occamy_ecc_event_collector.sv
// Scoreboard bench: a 16-bit-counter and a 2-bit-counter instance share stimulus.
module tb_occamy_ecc_event_collector;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][1:0]  bank_err;
  logic [3:0][15:0] bank_addr;
  logic             clear;

  logic [1:0]  ev, ev2, sat, sat2;
  logic [15:0] cc, cu, la, la2;
  logic [1:0]  cc2, cu2, lb, lb2;
  logic        lv, lu, lv2, lu2;

  always #5 clk = ~clk;

  occamy_ecc_event_collector #(.NumBanks(4), .AddrWidth(16), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .bank_err_i(bank_err), .bank_addr_i(bank_addr),
    .clear_i(clear), .event_ecc_rerror_o(ev), .cnt_corr_o(cc), .cnt_uncorr_o(cu),
    .cnt_sat_o(sat), .log_valid_o(lv), .log_uncorr_o(lu), .log_bank_o(lb),
    .log_addr_o(la));

  occamy_ecc_event_collector #(.NumBanks(4), .AddrWidth(16), .CntWidth(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .bank_err_i(bank_err), .bank_addr_i(bank_addr),
    .clear_i(clear), .event_ecc_rerror_o(ev2), .cnt_corr_o(cc2), .cnt_uncorr_o(cu2),
    .cnt_sat_o(sat2), .log_valid_o(lv2), .log_uncorr_o(lu2), .log_bank_o(lb2),
    .log_addr_o(la2));

  typedef struct {
    int ev; int cc; int cu; int sat; int cc2; int cu2; int sat2;
    int lv; int lu; int lb; int la;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state
  int m_state, m_lb, m_la, m_cc, m_cu, m_sat, m_cc2, m_cu2, m_sat2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cnt_model(input int base, input int n, input int maxv, input int satb,
                           output int nv, output int nsat);
    nv = base + n;
    nsat = satb;
    if (nv >= maxv) begin
      nv = maxv;
      nsat = 1;
    end
  endtask

  task automatic step(input logic [3:0][1:0] e, input logic [63:0] a,
                      input logic clr, input logic r);
    exp_t x;
    int nc, nu, fu, fc, s0, s1, tmp;
    @(negedge clk);
    bank_err = e; bank_addr = a; clear = clr; rst = r;
    nc = 0; nu = 0; fu = -1; fc = -1;
    for (int b = 0; b < 4; b++) begin
      if (e[b][1]) begin
        nu++;
        if (fu < 0) fu = b;
      end else if (e[b][0]) begin
        nc++;
        if (fc < 0) fc = b;
      end
    end
    x.ev = 0;
    if (r) begin
      m_state = 0; m_lb = 0; m_la = 0;
      m_cc = 0; m_cu = 0; m_sat = 0; m_cc2 = 0; m_cu2 = 0; m_sat2 = 0;
    end else begin
      x.ev = (nu > 0 ? 2 : 0) + (nc > 0 ? 1 : 0);
      if (clr) begin
        m_state = 0; m_lb = 0; m_la = 0;
        m_cc = 0; m_cu = 0; m_sat = 0; m_cc2 = 0; m_cu2 = 0; m_sat2 = 0;
      end
      cnt_model(m_cc, nc, 65535, m_sat % 2, m_cc, s0);
      cnt_model(m_cu, nu, 65535, m_sat / 2, m_cu, s1);
      m_sat = s0 + 2 * s1;
      cnt_model(m_cc2, nc, 3, m_sat2 % 2, m_cc2, s0);
      cnt_model(m_cu2, nu, 3, m_sat2 / 2, m_cu2, s1);
      m_sat2 = s0 + 2 * s1;
      if (m_state != 2 && fu >= 0) begin
        m_state = 2; m_lb = fu;
        tmp = fu * 16; m_la = int'(a[tmp +: 16]);
      end else if (m_state == 0 && fc >= 0) begin
        m_state = 1; m_lb = fc;
        tmp = fc * 16; m_la = int'(a[tmp +: 16]);
      end
    end
    x.cc = m_cc; x.cu = m_cu; x.sat = m_sat;
    x.cc2 = m_cc2; x.cu2 = m_cu2; x.sat2 = m_sat2;
    x.lv = (m_state != 0) ? 1 : 0; x.lu = (m_state == 2) ? 1 : 0;
    x.lb = m_lb; x.la = m_la;
    q.push_back(x);
  endtask

  // Monitor: every cycle is an output beat one edge after its stimulus
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("event", int'(ev), x.ev);
        chk("cnt_corr", int'(cc), x.cc);
        chk("cnt_uncorr", int'(cu), x.cu);
        chk("cnt_sat", int'(sat), x.sat);
        chk("log_valid", int'(lv), x.lv);
        chk("log_uncorr", int'(lu), x.lu);
        chk("log_bank", int'(lb), x.lb);
        chk("log_addr", int'(la), x.la);
        chk("s_event", int'(ev2), x.ev);
        chk("s_cnt_corr", int'(cc2), x.cc2);
        chk("s_cnt_uncorr", int'(cu2), x.cu2);
        chk("s_cnt_sat", int'(sat2), x.sat2);
        chk("s_log_valid", int'(lv2), x.lv);
        chk("s_log_uncorr", int'(lu2), x.lu);
        chk("s_log_bank", int'(lb2), x.lb);
        chk("s_log_addr", int'(la2), x.la);
      end
    end
  end

  localparam logic [63:0] A0 = 64'h4444_0123_2222_1111;

  initial begin
    rst = 1'b1; clear = 1'b0; bank_err = '0; bank_addr = '0;
    // Reset with every strobe and clear asserted, then a quiet cycle
    step(8'hFF, A0, 1'b1, 1'b1);
    step(8'hFF, A0, 1'b0, 1'b1);
    step(8'h00, A0, 1'b0, 1'b0);
    // Single correctable on bank 2 at 0x0123
    step(8'b00_01_00_00, A0, 1'b0, 1'b0);
    step(8'h00, A0, 1'b0, 1'b0);
    // Mixed cycle: bank1 corr, bank3 uncorr 0x0ABC, bank0 both bits
    step(8'h00, A0, 1'b1, 1'b0);
    step(8'b10_00_01_11, 64'h0ABC_3333_2222_0F00, 1'b0, 1'b0);
    step(8'b00_00_10_00, 64'h0ABC_3333_1234_0F00, 1'b0, 1'b0);
    // CORR on bank 1, ignored later corr, upgrade from bank 3 at 0x0055
    step(8'b00_00_01_00, 64'h0000_0000_0777_0000, 1'b1, 1'b0);
    step(8'b00_01_00_00, 64'h0000_0999_0000_0000, 1'b0, 1'b0);
    step(8'b10_00_00_00, 64'h0055_0000_0000_0000, 1'b0, 1'b0);
    // Four back-to-back single correctable errors saturate the 2-bit counter
    step(8'h00, A0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'b00_00_00_01, A0, 1'b0, 1'b0);
    step(8'h00, A0, 1'b1, 1'b0);
    step(8'h00, A0, 1'b0, 1'b0);
    // Build counts 5/7, then clear together with bank 0 uncorr at 0x0010
    step(8'b10_10_10_10, A0, 1'b0, 1'b0);
    step(8'b10_10_10_01, A0, 1'b0, 1'b0);
    step(8'b01_01_01_01, A0, 1'b0, 1'b0);
    step(8'b00_00_00_10, 64'h0000_0000_0000_0010, 1'b1, 1'b0);
    // Reset mid-operation drops strobes and clear of that cycle
    step(8'b01_10_00_00, A0, 1'b0, 1'b0);
    step(8'b11_11_01_10, A0, 1'b1, 1'b1);
    step(8'b00_00_01_00, 64'h0000_0000_BEEF_0000, 1'b0, 1'b0);
    step(8'h00, A0, 1'b0, 1'b0);
    step(8'h00, A0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
